// File: rtl/pipe_ctrl.sv
// pipe_ctrl: run/halt sequencer for the 16-bit five-stage core.
//
// Drives the exec/idle state seen by the IF/ID/EX/MEM/WB stage registers.
// Detects load-use hazards between ID and EX and answers them with a one-cycle
// stall plus bubble. Flushes the front end on a taken branch or jump. Drains the
// pipeline after HALT is decoded, and keeps saturating cycle and stall counters.
//
// Ports
//   i_clock          system clock; all state updates on posedge
//   i_reset          asynchronous active-high reset
//   i_start          one-cycle pulse; IDLE/HALTED -> RUN
//   i_id_ir          instruction in ID, opcode [15:11]
//   i_ex_ir          instruction in EX, opcode [15:11]
//   i_branch_taken   EX resolved a taken branch/JUMP/JMPR this cycle
//   o_state          1 in RUN/DRAIN, 0 in IDLE/HALTED
//   o_stall          hold PC, if_ir and id_ir
//   o_bubble         load ex_ir with NOP instead of id_ir
//   o_flush          replace if_ir and id_ir with NOP
//   o_halted         high only in HALTED
//   o_cycle_cnt      cycles spent in RUN or DRAIN (saturating)
//   o_stall_cnt      cycles with o_stall high (saturating)

module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [15:0]      i_id_ir,
    input  logic [15:0]      i_ex_ir,
    input  logic             i_branch_taken,
    output logic             o_state,
    output logic             o_stall,
    output logic             o_bubble,
    output logic             o_flush,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // Opcodes of the core's instruction set.
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    // Drain counter only ever holds DRAIN_CYCLES-1 down to 0.
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StHalted
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_drain_cnt;
    logic [DW-1:0]   w_drain_nxt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [4:0] w_id_op;
    logic [4:0] w_ex_op;
    logic [2:0] w_ex_dst;
    logic [2:0] w_src1;
    logic [2:0] w_src2;
    logic       w_src1_vld;
    logic       w_src2_vld;
    logic       w_hazard;
    logic       w_unused;

    assign w_id_op  = i_id_ir[15:11];
    assign w_ex_op  = i_ex_ir[15:11];
    assign w_ex_dst = i_ex_ir[10:8];

    // Register-read fields of the ID instruction, by opcode class.
    always_comb begin
        w_src1     = i_id_ir[6:4];
        w_src2     = i_id_ir[2:0];
        w_src1_vld = 1'b0;
        w_src2_vld = 1'b0;
        case (w_id_op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
                w_src1_vld = 1'b1;
                w_src2_vld = 1'b1;
            end
            OP_LOAD, OP_SLL, OP_SRL, OP_SLA, OP_SRA: begin
                w_src1_vld = 1'b1;
            end
            OP_STORE: begin
                // Store data register lives in the destination field.
                w_src2     = i_id_ir[10:8];
                w_src1_vld = 1'b1;
                w_src2_vld = 1'b1;
            end
            OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR, OP_ADDI, OP_SUBI,
            OP_LDIH: begin
                w_src1     = i_id_ir[10:8];
                w_src1_vld = 1'b1;
            end
            default: begin
                w_src1_vld = 1'b0;
                w_src2_vld = 1'b0;
            end
        endcase
    end

    assign w_hazard = (w_ex_op == OP_LOAD) &&
                      ((w_src1_vld && (w_src1 == w_ex_dst)) ||
                       (w_src2_vld && (w_src2 == w_ex_dst)));

    // Fields the controller never looks at.
    assign w_unused = ^{i_id_ir[7], i_id_ir[3], i_ex_ir[7:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        o_stall     = 1'b0;
        o_bubble    = 1'b0;
        o_flush     = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                // The ID instruction is discarded on a flush, so its hazard and a
                // HALT in ID are both moot.
                if (i_branch_taken) begin
                    o_flush = 1'b1;
                end else if (w_hazard) begin
                    o_stall  = 1'b1;
                    o_bubble = 1'b1;
                end else if (w_id_op == OP_HALT) begin
                    w_state_nxt = StDrain;
                    w_drain_nxt = DRAIN_LOAD;
                end
            end
            StDrain: begin
                o_stall  = 1'b1;
                o_bubble = 1'b1;
                if (r_drain_cnt == '0) begin
                    w_state_nxt = StHalted;
                end else begin
                    w_drain_nxt = r_drain_cnt - 1'b1;
                end
            end
            StHalted: begin
                if (i_start) begin
                    w_state_nxt = StRun;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign o_state  = (r_state == StRun) || (r_state == StDrain);
    assign o_halted = (r_state == StHalted);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Performance counters saturate at all-ones.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (o_state && !(&r_cycle_cnt)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (o_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule
